// File: rtl/hbr_responder.sv
// rtl/hbr_responder.sv - HyperBus memory responder: CA decode, latency, linear bursts, ID/CR registers
// Optional HBR_CFG_REG_EN: writable CR0 whose [7:4] selects the initial latency.
module hbr_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 6
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_csn,
    input  logic       i_ck,
    input  logic [7:0] i_dq,
    output logic [7:0] o_dq,
    output logic       o_dq_de,
    input  logic       i_rwds,
    output logic       o_rwds,
    output logic       o_rwds_de
);
    typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_WDATA, S_RDATA, S_REGW} state_t;
    localparam logic [15:0] CR0_RST = 16'h8F1F;

    state_t      state;
    logic        csn_r, csn_d, ck_r, ck_d, rwds_r;
    logic [7:0]  dq_r;
    logic [39:0] ca;
    logic [15:0] cnt;
    logic        odd;
    logic [31:0] addr;
    logic        is_read, is_reg;
    logic [7:0]  wbuf_hi, wbuf_lo;
    logic        mask_hi, mask_lo, wr_pend;
    logic [15:0] cr0;
    logic [15:0] mem [0:(1<<ADDR_W)-1];

    logic              edge_seen;
    logic [47:0]       ca_full;
    logic [15:0]       lat_edges, reg_word, rd_word;
    logic [ADDR_W-1:0] idx;
    logic              unused_ca;

    assign edge_seen = (ck_r != ck_d) && !csn_r;
    assign ca_full   = {ca, dq_r};
    assign idx       = addr[ADDR_W-1:0];
    assign unused_ca = ca_full[45];

`ifdef HBR_CFG_REG_EN
    always_comb begin
        case (cr0[7:4])
            4'h0:    lat_edges = 16'd20;
            4'h1:    lat_edges = 16'd24;
            4'h2:    lat_edges = 16'd28;
            4'hE:    lat_edges = 16'd12;
            4'hF:    lat_edges = 16'd16;
            default: lat_edges = 16'(4 * LATENCY);
        endcase
    end
`else
    assign cr0       = CR0_RST;
    assign lat_edges = 16'(4 * LATENCY);
`endif

    always_comb begin
        case (addr)
            32'h0000_0000: reg_word = 16'h0C81;
            32'h0000_0001: reg_word = 16'h0001;
            32'h0000_1000: reg_word = cr0;
            32'h0000_1001: reg_word = 16'hFFC1;
            default:       reg_word = 16'h0000;
        endcase
    end

    assign rd_word = is_reg ? reg_word : mem[idx];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            csn_r     <= 1'b1;
            csn_d     <= 1'b1;
            ck_r      <= 1'b0;
            ck_d      <= 1'b0;
            dq_r      <= 8'h00;
            rwds_r    <= 1'b0;
            state     <= S_IDLE;
            ca        <= '0;
            cnt       <= '0;
            odd       <= 1'b0;
            addr      <= '0;
            is_read   <= 1'b0;
            is_reg    <= 1'b0;
            wbuf_hi   <= 8'h00;
            wbuf_lo   <= 8'h00;
            mask_hi   <= 1'b1;
            mask_lo   <= 1'b1;
            wr_pend   <= 1'b0;
            o_dq      <= 8'h00;
            o_dq_de   <= 1'b0;
            o_rwds    <= 1'b0;
            o_rwds_de <= 1'b0;
`ifdef HBR_CFG_REG_EN
            cr0       <= CR0_RST;
`endif
        end else begin
            csn_r   <= i_csn;
            csn_d   <= csn_r;
            ck_r    <= i_ck;
            ck_d    <= ck_r;
            dq_r    <= i_dq;
            rwds_r  <= i_rwds;
            wr_pend <= 1'b0;
            // A completed word commits even if csn has already risen.
            if (wr_pend)
                addr <= addr + 32'd1;
            if (csn_r) begin
                state     <= S_IDLE;
                o_dq_de   <= 1'b0;
                o_rwds_de <= 1'b0;
                o_rwds    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        cnt <= '0;
                        odd <= 1'b0;
                        if (csn_d)
                            state <= S_CA;
                    end
                    S_CA: if (edge_seen) begin
                        ca        <= ca_full[39:0];
                        o_rwds    <= 1'b1;
                        o_rwds_de <= 1'b1;
                        if (cnt == 16'd5) begin
                            cnt     <= '0;
                            addr    <= {ca_full[44:16], ca_full[2:0]};
                            is_read <= ca_full[47];
                            is_reg  <= ca_full[46];
                            state   <= (!ca_full[47] && ca_full[46]) ? S_REGW : S_LAT;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    S_LAT: begin
                        o_rwds    <= 1'b0;
                        o_rwds_de <= 1'b0;
                        if (edge_seen) begin
                            if (cnt == lat_edges - 16'd1) begin
                                cnt   <= '0;
                                odd   <= 1'b0;
                                state <= is_read ? S_RDATA : S_WDATA;
                            end else begin
                                cnt <= cnt + 16'd1;
                            end
                        end
                    end
                    S_WDATA: if (edge_seen) begin
                        odd <= ~odd;
                        if (!odd) begin
                            wbuf_hi <= dq_r;
                            mask_hi <= rwds_r;
                        end else begin
                            wbuf_lo <= dq_r;
                            mask_lo <= rwds_r;
                            wr_pend <= 1'b1;
                        end
                    end
                    S_RDATA: if (edge_seen) begin
                        odd       <= ~odd;
                        o_dq_de   <= 1'b1;
                        o_rwds_de <= 1'b1;
                        o_rwds    <= ~odd;
                        o_dq      <= odd ? rd_word[7:0] : rd_word[15:8];
                        if (odd)
                            addr <= addr + 32'd1;
                    end
                    S_REGW: if (edge_seen) begin
                        odd <= ~odd;
                        if (!odd) begin
                            wbuf_hi <= dq_r;
                        end else begin
`ifdef HBR_CFG_REG_EN
                            if (addr == 32'h0000_1000)
                                cr0 <= {wbuf_hi, dq_r};
`endif
                            // Parking in IDLE with csn low ignores edges until csn cycles.
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_pend) begin
            if (!mask_hi)
                mem[idx][15:8] <= wbuf_hi;
            if (!mask_lo)
                mem[idx][7:0] <= wbuf_lo;
        end
    end

endmodule
